// File: rtl/fpu_pkg.sv
// fpu_pkg: rounding modes, flag bundle order and special-value builders shared by the FPU
package fpu_pkg;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    // flag bundle order {inv, ovf, unf, inx, zero}
    localparam int FLAG_INV  = 4;
    localparam int FLAG_OVF  = 3;
    localparam int FLAG_UNF  = 2;
    localparam int FLAG_INX  = 1;
    localparam int FLAG_ZERO = 0;

    // canonical quiet NaN {0, all-ones, 1 << (man_w-1)}, right-aligned in 64 bits
    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    // largest finite magnitude {all-ones-1, all-ones}, sign bit excluded
    function automatic logic [63:0] max_finite(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd2) << man_w) | ((64'd1 << man_w) - 64'd1);
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero count, returns W for an all-zero input
module fp_lzc #(
    parameter int W  = 25,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  x,
    output logic [CW-1:0] cnt
);

    // scan upward so the highest set bit wins
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++)
            if (x[i]) cnt = CW'(W - 1 - i);
    end

endmodule

// File: rtl/fp_add_sub_pipe.sv
// fp_add_sub_pipe: 3-stage pipelined IEEE-754 add/subtract with valid/ready handshake
module fp_add_sub_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 sub,
    input  logic [1:0]           round_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] z,
    output logic                 invalid_flag,
    output logic                 overflow_flag,
    output logic                 underflow_flag,
    output logic                 inexact_flag,
    output logic                 zero_flag
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 4;
    localparam int LW = $clog2(MW + 1);
    localparam int EW = EXP_W + LW + 1;
    localparam logic [EXP_W-1:0]     EMAX   = '1;
    localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);
    localparam logic [63:0]          NAN64  = canon_nan(EXP_W, MAN_W);
    localparam logic [63:0]          MAX64  = max_finite(EXP_W, MAN_W);
    localparam logic [W-1:0]         QNAN   = NAN64[W-1:0];
    localparam logic [W-2:0]         MAXF   = MAX64[W-2:0];

    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // ---------------- S1: unpack, order by magnitude, align ----------------
    logic             sa, sb, sbe, eff_sub, swap, sx;
    logic [EXP_W-1:0] ea, eb, ex, ey, d;
    logic [MAN_W-1:0] ma, mb;
    logic [MAN_W:0]   ua, ub, ux, uy;
    logic [MW-1:0]    ext_y, shr_y, mask_y, al_y;
    logic             a_nan, b_nan, a_inf, b_inf, spec, spec_inv;
    logic [W-1:0]     spec_z;

    assign {sa, ea, ma} = a;
    assign {sb, eb, mb} = b;
    assign sbe     = sb ^ sub;
    assign eff_sub = sa ^ sbe;
    assign ua      = (ea == '0) ? '0 : {1'b1, ma};
    assign ub      = (eb == '0) ? '0 : {1'b1, mb};
    assign swap    = {eb, ub} > {ea, ua};
    assign sx      = swap ? sbe : sa;
    assign ex      = swap ? eb : ea;
    assign ey      = swap ? ea : eb;
    assign ux      = swap ? ub : ua;
    assign uy      = swap ? ua : ub;
    assign d       = ex - ey;
    assign ext_y   = {uy, 3'b000};
    assign shr_y   = ext_y >> d;
    assign mask_y  = ~({MW{1'b1}} << d);
    assign al_y    = {shr_y[MW-1:1], shr_y[0] | (|(ext_y & mask_y))};

    assign a_nan    = (ea == EMAX) && (ma != '0);
    assign b_nan    = (eb == EMAX) && (mb != '0);
    assign a_inf    = (ea == EMAX) && (ma == '0);
    assign b_inf    = (eb == EMAX) && (mb == '0);
    assign spec     = a_nan | b_nan | a_inf | b_inf;
    assign spec_inv = a_inf & b_inf & eff_sub;
    assign spec_z   = (a_nan | b_nan | spec_inv) ? QNAN : a_inf ? a : {sbe, EMAX, {MAN_W{1'b0}}};

    logic             s1_valid, s1_spec, s1_inv, s1_sign, s1_eff_sub;
    logic [W-1:0]     s1_sz;
    logic [EXP_W-1:0] s1_exp;
    logic [MW-1:0]    s1_mx, s1_my;
    logic [1:0]       s1_rm;

    // ---------------- S2: add/subtract and normalise ----------------
    logic [MW:0]            sum;
    logic [LW-1:0]          lz;
    logic [MW-1:0]          norm;
    logic signed [EW-1:0]   exp2;
    logic                   sum_zero, sign2;

    assign sum = s1_eff_sub ? {1'b0, s1_mx} - {1'b0, s1_my} : {1'b0, s1_mx} + {1'b0, s1_my};

    fp_lzc #(.W(MW)) u_lzc (.x(sum[MW-1:0]), .cnt(lz));

    assign norm     = sum[MW] ? {sum[MW:2], sum[1] | sum[0]} : sum[MW-1:0] << lz;
    assign exp2     = sum[MW] ? EW'(s1_exp) + EW'(1) : EW'(s1_exp) - EW'(lz);
    assign sum_zero = sum == '0;
    assign sign2    = (sum_zero & s1_eff_sub) ? (s1_rm == RM_RDN) : s1_sign;

    logic                 s2_valid, s2_spec, s2_inv, s2_sign, s2_zero;
    logic [W-1:0]         s2_sz;
    logic signed [EW-1:0] s2_exp;
    logic [MW-1:0]        s2_man;
    logic [1:0]           s2_rm;

    // ---------------- S3: round, range check, pack ----------------
    logic                 grs, up, rc, ovf, ftz, ovf_inf, arith;
    logic [MAN_W+1:0]     rnd;
    logic [MAN_W-1:0]     frac;
    logic signed [EW-1:0] exp3;
    logic [W-1:0]         z_n;
    logic [4:0]           flags_n, flags;

    assign grs  = |s2_man[2:0];
    assign up   = (s2_rm == RM_RNE) ? s2_man[2] & (s2_man[1] | s2_man[0] | s2_man[3])
                : (s2_rm == RM_RTZ) ? 1'b0
                : (s2_rm == RM_RUP) ? ~s2_sign & grs
                :                     s2_sign & grs;
    assign rnd  = {1'b0, s2_man[MW-1:3]} + {{(MAN_W+1){1'b0}}, up};
    assign rc   = rnd[MAN_W+1];
    assign frac = rc ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    assign exp3 = s2_exp + {{(EW-1){1'b0}}, rc};
    assign ovf  = exp3 >= EMAX_S;
    assign ftz  = exp3[EW-1] || (exp3 == '0);
    assign ovf_inf = (s2_rm == RM_RNE) || (s2_rm == RM_RUP && !s2_sign) || (s2_rm == RM_RDN && s2_sign);
    assign arith   = !s2_spec && !s2_zero;

    assign z_n = s2_spec           ? s2_sz
               : (s2_zero || ftz)  ? {s2_sign, {(W-1){1'b0}}}
               : ovf               ? {s2_sign, ovf_inf ? {EMAX, {MAN_W{1'b0}}} : MAXF}
               :                     {s2_sign, exp3[EXP_W-1:0], frac};

    // status flags for the result being packed
    always_comb begin
        flags_n            = '0;
        flags_n[FLAG_INV]  = s2_spec & s2_inv;
        flags_n[FLAG_OVF]  = arith & ovf;
        flags_n[FLAG_UNF]  = arith & ftz;
        flags_n[FLAG_INX]  = arith & (grs | ovf | ftz);
        flags_n[FLAG_ZERO] = !s2_spec & (s2_zero | ftz);
    end

    // stage valid bits and output register; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            z         <= '0;
            flags     <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            z         <= z_n;
            flags     <= flags_n;
        end
    end

    // stage payloads shift with the shared advance enable
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_spec    <= spec;
            s1_inv     <= spec_inv;
            s1_sz      <= spec_z;
            s1_sign    <= sx;
            s1_eff_sub <= eff_sub;
            s1_exp     <= ex;
            s1_mx      <= {ux, 3'b000};
            s1_my      <= al_y;
            s1_rm      <= round_mode;
            s2_spec    <= s1_spec;
            s2_inv     <= s1_inv;
            s2_sz      <= s1_sz;
            s2_sign    <= sign2;
            s2_zero    <= sum_zero;
            s2_exp     <= exp2;
            s2_man     <= norm;
            s2_rm      <= s1_rm;
        end
    end

    assign invalid_flag   = flags[FLAG_INV];
    assign overflow_flag  = flags[FLAG_OVF];
    assign underflow_flag = flags[FLAG_UNF];
    assign inexact_flag   = flags[FLAG_INX];
    assign zero_flag      = flags[FLAG_ZERO];

endmodule
